// File: rtl/scan_chain_ctrl_pkg.sv
// Shared definitions for the scan chain controller: FSM state encoding
// and the default chain-length width.
package scan_chain_ctrl_pkg;

  localparam int LEN_W_DEF = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
  localparam logic [2:0] ST_CAPTURE   = 3'd2;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd3;
  localparam logic [2:0] ST_FIN       = 3'd4;

endpackage

// File: rtl/scan_shift_cnt.sv
// Loadable down-counter that tracks the remaining shifts in a scan phase.
// Load wins over decrement; the count saturates at zero instead of wrapping.
module scan_shift_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic [LEN_W-1:0] cnt,
  output logic             is_one
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - LEN_W'(1);
    end
  end

  assign is_one = (cnt == LEN_W'(1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: streams stimulus into one chain, optionally pulses a
// functional capture, then unloads the chain tail-first on a valid-only stream.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             CAP_EN,
  input  logic             SI,
  input  logic             SI_VALID,
  output logic             SI_READY,
  input  logic             SCAN_OUT,
  output logic             SCAN_IN,
  output logic             SE,
  output logic             CHAIN_CE,
  output logic             SO,
  output logic             SO_VALID,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] n_lat;
  logic             cap_lat;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] load_val;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_is_one;
  logic             start_ok;
  logic             shift;

  assign start_ok = (state == ST_IDLE) && START && (LEN != '0);
  assign shift    = ((state == ST_SHIFT_IN) && SI_VALID) || (state == ST_SHIFT_OUT);
  assign cnt_load = start_ok || (state == ST_CAPTURE);
  assign cnt_dec  = shift && (cnt != '0);
  assign load_val = (state == ST_IDLE) ? LEN : n_lat;

  scan_shift_cnt #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk     (CLK),
    .rst_n   (R),
    .load    (cnt_load),
    .load_val(load_val),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .is_one  (cnt_is_one)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = (LEN != '0) ? ST_SHIFT_IN : ST_FIN;
        end
      end
      ST_SHIFT_IN: begin
        if (SI_VALID && cnt_is_one) begin
          state_nxt = cap_lat ? ST_CAPTURE : ST_FIN;
        end
      end
      ST_CAPTURE:   state_nxt = ST_SHIFT_OUT;
      ST_SHIFT_OUT: begin
        if (cnt_is_one) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN:       state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequence parameters are only consumed while busy, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (start_ok) begin
      n_lat   <= LEN;
      cap_lat <= CAP_EN;
    end
  end

  // Unload stage: the tail bit seen on a shift edge is presented the next cycle.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      SO       <= 1'b0;
      SO_VALID <= 1'b0;
    end else begin
      SO_VALID <= shift;
      if (shift) begin
        SO <= SCAN_OUT;
      end
    end
  end

  always_comb begin
    SI_READY = 1'b0;
    SCAN_IN  = 1'b0;
    SE       = 1'b0;
    CHAIN_CE = 1'b0;
    BUSY     = (state != ST_IDLE);
    DONE     = (state == ST_FIN);
    case (state)
      ST_SHIFT_IN: begin
        SI_READY = 1'b1;
        SCAN_IN  = SI;
        SE       = 1'b1;
        CHAIN_CE = SI_VALID;
      end
      ST_CAPTURE: begin
        CHAIN_CE = 1'b1;
      end
      ST_SHIFT_OUT: begin
        SE       = 1'b1;
        CHAIN_CE = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an external scan-chain model: table vectors,
// reset/ignore-START corner sequences and randomized runs against a stream reference.
module tb_scan_chain_ctrl;

  localparam int LEN_W = 8;
  localparam int MAX_K = 1000;

  logic             clk;
  logic             r;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             cap_en;
  logic             si;
  logic             si_valid;
  logic             si_ready;
  logic             scan_out;
  logic             scan_in;
  logic             se;
  logic             chain_ce;
  logic             so;
  logic             so_valid;
  logic             busy;
  logic             done;

  scan_chain_ctrl #(.LEN_W(LEN_W)) dut (
    .CLK(clk), .R(r), .START(start), .LEN(len), .CAP_EN(cap_en),
    .SI(si), .SI_VALID(si_valid), .SI_READY(si_ready),
    .SCAN_OUT(scan_out), .SCAN_IN(scan_in), .SE(se), .CHAIN_CE(chain_ce),
    .SO(so), .SO_VALID(so_valid), .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit chain_q [256];
  bit pre_q   [256];
  bit func_d  [256];
  bit stim    [257];
  bit vsched  [MAX_K+1];
  int chain_len = 1;
  bit pre_load  = 1'b0;

  // Chain of positive-edge DFFs: index 0 is the head, chain_len-1 the tail.
  assign scan_out = chain_q[chain_len-1];

  always @(posedge clk) begin
    if (pre_load) begin
      chain_q <= pre_q;
    end else if (chain_ce) begin
      if (se) begin
        chain_q[0] <= scan_in;
        for (int i = 1; i < 256; i++) chain_q[i] <= chain_q[i-1];
      end else begin
        chain_q <= func_d;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  bit got_so    [$];
  bit exp_so    [$];
  bit exp_final [$];
  int done_k, done_cnt, ce_cnt, cap_cnt;
  bit ready0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s_si_ready", tag), si_ready, 0);
    chk($sformatf("%s_scan_in", tag), scan_in, 0);
    chk($sformatf("%s_se", tag), se, 0);
    chk($sformatf("%s_chain_ce", tag), chain_ce, 0);
    chk($sformatf("%s_so", tag), so, 0);
    chk($sformatf("%s_so_valid", tag), so_valid, 0);
    chk($sformatf("%s_busy", tag), busy, 0);
    chk($sformatf("%s_done", tag), done, 0);
  endtask

  // k counts clock edges after the START edge; k=0 is the first cycle after it.
  task automatic run_seq(input int n, input bit cap, input bit noise);
    int k;
    int sidx;
    bit hs;
    bit fin_seen;
    chain_len = (n == 0) ? 1 : n;
    got_so.delete();
    done_k = -1; done_cnt = 0; ce_cnt = 0; cap_cnt = 0; ready0 = 1'b0;
    sidx = 0; fin_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(n); cap_en = cap; pre_load = 1'b1;
    si_valid = 1'b0; si = stim[0];
    @(posedge clk);
    #1;
    pre_load = 1'b0;
    if (!noise) start = 1'b0;
    k = 0;
    while (!fin_seen && k <= MAX_K) begin
      si_valid = vsched[k];
      si = stim[sidx];
      if (noise) begin
        len = LEN_W'($urandom);
        cap_en = 1'($urandom);
      end
      @(negedge clk);
      if (so_valid) got_so.push_back(so);
      if (chain_ce) ce_cnt++;
      if (chain_ce && !se) cap_cnt++;
      if (k == 0) ready0 = si_ready;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        fin_seen = 1'b1;
      end
      hs = si_ready && si_valid;
      @(posedge clk);
      #1;
      if (hs && sidx < 256) sidx++;
      k++;
    end
    start = 1'b0; si_valid = 1'b0; si = 1'b0;
    @(negedge clk);
    chk("after_done_busy", busy, 0);
    chk("after_done_done", done, 0);
    chk("after_done_se", se, 0);
    chk("after_done_so_valid", so_valid, 0);
    @(negedge clk);
    chk("still_idle_busy", busy, 0);
  endtask

  task automatic verify(input string tag, input int e_done, input int e_ce,
                        input int e_cap, input bit e_ready0);
    chk($sformatf("%s_done_cycle", tag), done_k, e_done);
    chk($sformatf("%s_done_pulses", tag), done_cnt, 1);
    chk($sformatf("%s_ce_cycles", tag), ce_cnt, e_ce);
    chk($sformatf("%s_capture_cycles", tag), cap_cnt, e_cap);
    chk($sformatf("%s_first_ready", tag), ready0, e_ready0);
    chk($sformatf("%s_so_count", tag), got_so.size(), exp_so.size());
    for (int i = 0; i < exp_so.size() && i < got_so.size(); i++)
      chk($sformatf("%s_so_bit%0d", tag, i), got_so[i], exp_so[i]);
    for (int i = 0; i < exp_final.size(); i++)
      chk($sformatf("%s_chain_bit%0d", tag, i), chain_q[i], exp_final[i]);
  endtask

  // Reference: unload = old contents tail-first, then captured data tail-first;
  // the first stimulus bit ends at the tail; timing follows from counting valids.
  task automatic build_expect(input int n, input bit cap, output int e_done, output int e_ce);
    int cnt;
    int k;
    exp_so.delete();
    exp_final.delete();
    for (int i = n - 1; i >= 0; i--) exp_so.push_back(pre_q[i]);
    if (cap) for (int i = n - 1; i >= 0; i--) exp_so.push_back(func_d[i]);
    for (int i = 0; i < n; i++) exp_final.push_back(cap ? 1'b0 : stim[n-1-i]);
    cnt = 0;
    k = 0;
    while (cnt < n && k <= MAX_K) begin
      if (vsched[k]) cnt++;
      k++;
    end
    e_done = (n == 0) ? 0 : k + (cap ? n + 1 : 0);
    e_ce   = (n == 0) ? 0 : n + (cap ? n + 1 : 0);
  endtask

  task automatic randomize_data(input int stall_pct);
    for (int i = 0; i < 256; i++) begin
      pre_q[i]  = 1'($urandom);
      func_d[i] = 1'($urandom);
      stim[i]   = 1'($urandom);
    end
    stim[256] = 1'b0;
    for (int k = 0; k <= MAX_K; k++)
      vsched[k] = (k >= 200) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
  endtask

  typedef struct {
    int         n;
    bit         cap;
    logic [7:0] pre;
    logic [7:0] fd;
    logic [7:0] stimv;
    int         stall_at;
    int         stall_len;
    bit         noise;
    int         e_done;
    int         e_so_n;
    logic [15:0] e_so;
    int         e_ce;
    int         e_cap;
    bit         chk_final;
    logic [7:0] e_final;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e_done;
    int e_ce;
    int n;
    bit cap;
    r = 1'b0; start = 1'b0; len = '0; cap_en = 1'b0; si = 1'b0; si_valid = 1'b0;

    // Expected bit i of e_so is the i-th emitted SO bit; pre/fd/e_final bit i is chain flop i.
    vecs[0] = '{4, 1'b0, 8'b1001, 8'b0000, 8'b1101, 0, 0, 1'b0, 4, 4, 16'b0000_0000_0000_1001, 4, 0, 1'b1, 8'b1011};
    vecs[1] = '{4, 1'b1, 8'b1001, 8'b0110, 8'b1101, 0, 0, 1'b0, 9, 8, 16'b0000_0000_0110_1001, 9, 1, 1'b1, 8'b0000};
    vecs[2] = '{3, 1'b0, 8'b0101, 8'b0000, 8'b0110, 1, 2, 1'b0, 5, 3, 16'b0000_0000_0000_0101, 3, 0, 1'b1, 8'b0011};
    vecs[3] = '{0, 1'b1, 8'b0000, 8'b0000, 8'b0000, 0, 0, 1'b0, 0, 0, 16'b0,                   0, 0, 1'b0, 8'b0000};
    vecs[4] = '{1, 1'b1, 8'b0001, 8'b0000, 8'b0001, 0, 0, 1'b0, 3, 2, 16'b0000_0000_0000_0001, 3, 1, 1'b1, 8'b0000};
    vecs[5] = '{4, 1'b1, 8'b0110, 8'b1010, 8'b1100, 0, 0, 1'b1, 9, 8, 16'b0000_0000_0101_0110, 9, 1, 1'b1, 8'b0000};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 r = 1'b1;
    @(negedge clk);
    chk("idle_after_reset_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 256; i++) begin
        pre_q[i] = 1'b0; func_d[i] = 1'b0; stim[i] = 1'b0;
      end
      stim[256] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        pre_q[i]  = vecs[v].pre[i];
        func_d[i] = vecs[v].fd[i];
        stim[i]   = vecs[v].stimv[i];
      end
      for (int k = 0; k <= MAX_K; k++)
        vsched[k] = !(k >= vecs[v].stall_at && k < vecs[v].stall_at + vecs[v].stall_len);
      exp_so.delete();
      exp_final.delete();
      for (int i = 0; i < vecs[v].e_so_n; i++) exp_so.push_back(vecs[v].e_so[i]);
      if (vecs[v].chk_final)
        for (int i = 0; i < vecs[v].n; i++) exp_final.push_back(vecs[v].e_final[i]);
      run_seq(vecs[v].n, vecs[v].cap, vecs[v].noise);
      verify($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_ce, vecs[v].e_cap, vecs[v].n != 0);
    end

    // Reset pulse in the middle of the unload phase of an 8-bit sequence.
    randomize_data(0);
    chain_len = 8;
    @(negedge clk);
    start = 1'b1; len = 8'd8; cap_en = 1'b1; si_valid = 1'b1; si = 1'b0; pre_load = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; pre_load = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_se", se, 1);
    chk("pre_reset_chain_ce", chain_ce, 1);
    chk("pre_reset_si_ready", si_ready, 0);
    r = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    si_valid = 1'b0;
    @(posedge clk);
    #2 r = 1'b1;
    #1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_done", done, 0);
    randomize_data(30);
    build_expect(3, 1'b0, e_done, e_ce);
    run_seq(3, 1'b0, 1'b0);
    verify("restart", e_done, e_ce, 0, 1'b1);

    for (int it = 0; it < 25; it++) begin
      n = (it == 0) ? 255 : (($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20));
      cap = 1'($urandom);
      randomize_data(30);
      build_expect(n, cap, e_done, e_ce);
      run_seq(n, cap, 1'($urandom));
      verify($sformatf("rand%0d", it), e_done, e_ce, (cap && n != 0) ? 1 : 0, n != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequences a scan chain built from positive-edge D flip-flops: shift-in, optional capture, shift-out.
- Streams stimulus bits in through a valid/ready handshake and returns unloaded bits on a valid-only stream.
- Drives the chain's scan-enable and clock-enable.
- Sits between the test-access logic and one scan chain in the SoC.

Parameters:
- LEN_W, 8, width of chain-length input; maximum chain length is 2^LEN_W-1.

Ports:
- CLK  input  1  rising-edge clock shared with the chain flops
- R  input  1  asynchronous active-low reset
- START  input  1  begin a sequence; sampled only in IDLE
- LEN  input  LEN_W  chain length N; latched on accepted START
- CAP_EN  input  1  include capture phase; latched on accepted START
- SI  input  1  stimulus bit
- SI_VALID  input  1  SI holds a valid bit
- SI_READY  output  1  controller accepts SI this cycle
- SCAN_OUT  input  1  tail of chain
- SCAN_IN  output  1  head of chain
- SE  output  1  scan-enable (1 = shift path, 0 = functional capture)
- CHAIN_CE  output  1  chain clock-enable; chain flops update only on edges where it is 1
- SO  output  1  unloaded bit
- SO_VALID  output  1  SO valid; one-cycle pulse per bit, no backpressure
- BUSY  output  1  state != IDLE
- DONE  output  1  one-cycle pulse at sequence end

Behaviour:
- Reset: one clock CLK; reset is asynchronous and active-low on R. Assertion forces state IDLE, counter 0, and all outputs 0 immediately. This includes reset mid-sequence, where chain contents are undefined and no DONE is issued.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN.
- IDLE:
  - START=1 with LEN!=0: latch N and CAP_EN, load counter with N, go to SHIFT_IN.
  - START=1 with LEN=0: go to FIN.
  - START while not in IDLE is ignored.
- SHIFT_IN:
  - SI_READY=1, SE=1, SCAN_IN=SI, CHAIN_CE=SI_VALID.
  - Each edge with SI_VALID=1 is a shift: counter decrements; SO<=SCAN_OUT; SO_VALID=1 in the following cycle.
  - SI_VALID=0 stalls: CHAIN_CE=0, counter holds, no SO_VALID.
  - On the shift with counter==1: go to CAPTURE if CAP_EN, else FIN.
- CAPTURE:
  - Exactly one cycle: SE=0, CHAIN_CE=1, SI_READY=0.
  - Reload counter with N; go to SHIFT_OUT.
- SHIFT_OUT:
  - SE=1, CHAIN_CE=1 every cycle, SCAN_IN=0, SI_READY=0.
  - Each edge is a shift: SO<=SCAN_OUT, SO_VALID next cycle, counter decrements.
  - When counter==1: go to FIN.
- FIN: DONE=1 for one cycle, BUSY=1; go to IDLE. A START in the FIN cycle is ignored.
- Outputs by state:
  - SCAN_IN=0, SE=0, CHAIN_CE=0 outside SHIFT_IN/SHIFT_OUT/CAPTURE.
  - SO holds its last value; SO_VALID is 0 except the cycle after a shift.
- Ordering: stimulus bit 1 travels furthest (ends at the tail). SO emits tail-first.
- Latency:
  - START edge to first SI_READY: 1 cycle.
  - Full sequence with CAP_EN, no stalls: 1 + N + 1 + N + 1 cycles.
- SO_VALID for the last shift-out bit coincides with DONE.
- Counter is LEN_W bits and never wraps: decrement only on a shift with counter>=1.

Decomposition:
- Package scan_chain_ctrl_pkg holds:
  - the state encoding constants (IDLE=0, SHIFT_IN=1, CAPTURE=2, SHIFT_OUT=3, FIN=4; 3 bits);
  - the LEN_W default.
- One sub-module, scan_shift_cnt: loadable down-counter with load, dec, and is_one outputs; async active-low reset.
- FSM and output decode stay in the top.

Test Plan:
- Chain model is four DFFs preloaded 4'b1001. START, LEN=4, CAP_EN=0, SI=1,0,1,1 with SI_VALID constant -> SO stream 1,0,0,1; chain ends holding stimulus; DONE 6 cycles after START edge; SE=0 afterward.
- LEN=4, CAP_EN=1, functional D of the model = 4'b0110 -> CAPTURE cycle has SE=0 and CHAIN_CE=1; shift-out SO = 0,1,1,0; DONE at cycle 11.
- LEN=3 with SI_VALID low for 2 cycles mid-shift -> CHAIN_CE=0 and counter frozen during the stall; total shift-in edges exactly 3; DONE delayed by 2.
- START with LEN=0 -> no CHAIN_CE, no SO_VALID; DONE pulse 2 cycles after START.
- R low for 1 cycle in SHIFT_OUT with LEN=8 -> all outputs 0 immediately, BUSY=0, no DONE; a new START is accepted next cycle.
- START re-asserted during SHIFT_IN and in the FIN cycle -> ignored; LEN change mid-sequence has no effect.
